// File: rtl/sequence_player.sv
// sequence_player: plays a stored note sequence for one game round, one note
// at a time. Each note is loaded from pattern memory, sounds for NOTE_TICKS
// ticks and is followed by GAP_TICKS silent ticks. A tick is TICK_DIV clocks.
// The round controller starts playback and can cut it short with abort.
module sequence_player #(
  parameter int TICK_DIV   = 5_000_000,
  parameter int NOTE_TICKS = 5,
  parameter int GAP_TICKS  = 2,
  parameter int MAX_LEN    = 16,
  parameter int NOTE_W     = 3,
  localparam int IDX_W     = $clog2(MAX_LEN)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [IDX_W:0]    seq_len,
  input  logic [NOTE_W-1:0] note_in,
  output logic [IDX_W-1:0]  rd_index,
  output logic [NOTE_W-1:0] note_out,
  output logic              note_valid,
  output logic              is_music_playing,
  output logic              reset_current_index,
  output logic              done,
  output logic              aborted
);

  localparam int DIV_W     = $clog2(TICK_DIV);
  localparam int MAX_TICKS = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
  localparam int TCNT_W    = $clog2(MAX_TICKS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(TICK_DIV - 1);
  localparam logic [TCNT_W-1:0] NOTE_LAST = TCNT_W'(NOTE_TICKS - 1);
  // With no gap the GAP state is never entered; the constant only has to be legal.
  localparam logic [TCNT_W-1:0] GAP_LAST  = TCNT_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
  localparam logic [IDX_W:0]    MAX_LEN_L = (IDX_W + 1)'(MAX_LEN);
  localparam logic [IDX_W:0]    LEN_ONE   = (IDX_W + 1)'(1);

  typedef enum logic [2:0] {IDLE, LOAD, NOTE, GAP, DONE} state_t;

  state_t            state;
  logic [DIV_W-1:0]  tick_ctr;
  logic [TCNT_W-1:0] tick_cnt;
  logic [IDX_W:0]    len;
  logic              tick;
  logic              last_note;

  // A tick is the last clock of each TICK_DIV-clock period of the divider.
  assign tick = (tick_ctr == DIV_LAST);

  // The current note is the final one of the latched sequence length.
  assign last_note = ({1'b0, rd_index} == (len - LEN_ONE));

  // Playback state machine; every output is registered here, pulses default low.
  always_ff @(posedge clock) begin
    if (reset) begin
      state               <= IDLE;
      tick_ctr            <= '0;
      tick_cnt            <= '0;
      len                 <= '0;
      rd_index            <= '0;
      note_out            <= '0;
      note_valid          <= 1'b0;
      is_music_playing    <= 1'b0;
      reset_current_index <= 1'b0;
      done                <= 1'b0;
      aborted             <= 1'b0;
    end else begin
      reset_current_index <= 1'b0;
      done                <= 1'b0;
      aborted             <= 1'b0;

      if (abort && state != IDLE) begin
        state            <= IDLE;
        aborted          <= 1'b1;
        note_valid       <= 1'b0;
        is_music_playing <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !abort) begin
              len                 <= (seq_len > MAX_LEN_L) ? MAX_LEN_L : seq_len;
              rd_index            <= '0;
              reset_current_index <= 1'b1;
              is_music_playing    <= 1'b1;
              if (seq_len == '0) begin
                state <= DONE;
                done  <= 1'b1;
              end else begin
                state <= LOAD;
              end
            end
          end

          LOAD: begin
            note_out   <= note_in;
            tick_ctr   <= '0;
            tick_cnt   <= '0;
            note_valid <= 1'b1;
            state      <= NOTE;
          end

          NOTE: begin
            if (tick) begin
              tick_ctr <= '0;
              if (tick_cnt == NOTE_LAST) begin
                tick_cnt   <= '0;
                note_valid <= 1'b0;
                if (GAP_TICKS == 0) begin
                  if (last_note) begin
                    state <= DONE;
                    done  <= 1'b1;
                  end else begin
                    rd_index <= rd_index + IDX_W'(1);
                    state    <= LOAD;
                  end
                end else begin
                  state <= GAP;
                end
              end else begin
                tick_cnt <= tick_cnt + TCNT_W'(1);
              end
            end else begin
              tick_ctr <= tick_ctr + DIV_W'(1);
            end
          end

          GAP: begin
            if (tick) begin
              tick_ctr <= '0;
              if (tick_cnt == GAP_LAST) begin
                tick_cnt <= '0;
                if (last_note) begin
                  state <= DONE;
                  done  <= 1'b1;
                end else begin
                  rd_index <= rd_index + IDX_W'(1);
                  state    <= LOAD;
                end
              end else begin
                tick_cnt <= tick_cnt + TCNT_W'(1);
              end
            end else begin
              tick_ctr <= tick_ctr + DIV_W'(1);
            end
          end

          DONE: begin
            state            <= IDLE;
            is_music_playing <= 1'b0;
          end

          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sequence_player.sv
// tb_sequence_player: directed, table-driven bench for sequence_player.
// dut1 uses the short-tick build with a gap; dut2 is the same design with no gap.
module tb_sequence_player;

  logic       clock;
  logic       reset;

  logic       start1, abort1;
  logic [4:0] seq_len1;
  logic [2:0] note_in1;
  logic [3:0] rd_index1;
  logic [2:0] note_out1;
  logic       vld1, play1, rci1, done1, abt1;

  logic       start2, abort2;
  logic [4:0] seq_len2;
  logic [2:0] note_in2;
  logic [3:0] rd_index2;
  logic [2:0] note_out2;
  logic       vld2, play2, rci2, done2, abt2;

  logic [2:0] mem1 [16];
  logic [2:0] mem2 [16];

  int n_checks = 0;
  int n_fails  = 0;

  typedef struct {
    logic       start;
    logic       abort;
    logic       vld;
    logic       play;
    logic       rci;
    logic       dn;
    logic       abt;
    logic [3:0] idx;
    logic [2:0] note;
  } vec_t;

  vec_t vecs [42];

  assign note_in1 = mem1[rd_index1];
  assign note_in2 = mem2[rd_index2];

  sequence_player #(.TICK_DIV(4), .NOTE_TICKS(2), .GAP_TICKS(1), .MAX_LEN(16), .NOTE_W(3)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .abort(abort1), .seq_len(seq_len1),
    .note_in(note_in1), .rd_index(rd_index1), .note_out(note_out1), .note_valid(vld1),
    .is_music_playing(play1), .reset_current_index(rci1), .done(done1), .aborted(abt1));

  sequence_player #(.TICK_DIV(4), .NOTE_TICKS(2), .GAP_TICKS(0), .MAX_LEN(16), .NOTE_W(3)) dut2 (
    .clock(clock), .reset(reset), .start(start2), .abort(abort2), .seq_len(seq_len2),
    .note_in(note_in2), .rd_index(rd_index2), .note_out(note_out2), .note_valid(vld2),
    .is_music_playing(play2), .reset_current_index(rci2), .done(done2), .aborted(abt2));

  // Free-running 10-unit clock
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Expected behaviour of the 3-note round {5,2,7} after edge Ek, optionally cut at abort_at
  function automatic vec_t mkVec(int k, int abort_at);
    vec_t v;
    bit   cut;
    int   kk;
    cut    = (abort_at >= 0) && (k >= abort_at);
    kk     = cut ? abort_at : k;
    v.start = (k == 0);
    v.abort = (k == abort_at);
    v.vld   = !cut && ((k >= 1 && k <= 8) || (k >= 14 && k <= 21) || (k >= 27 && k <= 34));
    v.play  = !cut && (k <= 39);
    v.rci   = (k == 0);
    v.dn    = !cut && (k == 39);
    v.abt   = (k == abort_at);
    v.idx   = (kk <= 12) ? 4'd0 : (kk <= 25) ? 4'd1 : 4'd2;
    v.note  = (k <= 12) ? 3'd5 : (k <= 25) ? 3'd2 : 3'd7;
    return v;
  endfunction

  // Drive one clock of stimulus into the selected DUT, then sample 1 unit after the edge
  task automatic applyStimulus(input bit which, input logic st, input logic ab, input logic [4:0] len);
    if (which == 1'b0) begin
      start1 = st; abort1 = ab; seq_len1 = len;
    end else begin
      start2 = st; abort2 = ab; seq_len2 = len;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkFlags1(input string tag, input logic vld, input logic play,
                             input logic rci, input logic dn, input logic abt);
    checkOutput({tag, " note_valid"}, 32'(vld1), 32'(vld));
    checkOutput({tag, " is_music_playing"}, 32'(play1), 32'(play));
    checkOutput({tag, " reset_current_index"}, 32'(rci1), 32'(rci));
    checkOutput({tag, " done"}, 32'(done1), 32'(dn));
    checkOutput({tag, " aborted"}, 32'(abt1), 32'(abt));
  endtask

  task automatic runTable(input string tag);
    for (int k = 0; k < 42; k++) begin
      applyStimulus(1'b0, vecs[k].start, vecs[k].abort, 5'd3);
      checkFlags1($sformatf("%s E%0d", tag, k), vecs[k].vld, vecs[k].play,
                  vecs[k].rci, vecs[k].dn, vecs[k].abt);
      checkOutput($sformatf("%s E%0d rd_index", tag, k), 32'(rd_index1), 32'(vecs[k].idx));
      if (vecs[k].vld)
        checkOutput($sformatf("%s E%0d note_out", tag, k), 32'(note_out1), 32'(vecs[k].note));
    end
    start1 = 1'b0;
    abort1 = 1'b0;
  endtask

  initial begin
    int note_cnt, max_idx, done_at, rci_extra;
    logic prev_vld;

    reset = 1'b1;
    start1 = 1'b0; abort1 = 1'b0; seq_len1 = '0;
    start2 = 1'b0; abort2 = 1'b0; seq_len2 = '0;
    for (int i = 0; i < 16; i++) begin
      mem1[i] = '0;
      mem2[i] = '0;
    end
    mem1[0] = 3'd5; mem1[1] = 3'd2; mem1[2] = 3'd7;
    mem2[0] = 3'd3; mem2[1] = 3'd6;

    // Power-on reset state
    repeat (3) @(posedge clock);
    #1;
    checkFlags1("por", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("por rd_index", 32'(rd_index1), 32'd0);
    checkOutput("por note_out", 32'(note_out1), 32'd0);
    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);

    // Full 3-note round
    for (int k = 0; k < 42; k++) vecs[k] = mkVec(k, -1);
    runTable("play3");

    // Same round cut by abort at E16
    for (int k = 0; k < 42; k++) vecs[k] = mkVec(k, 16);
    runTable("abort16");

    // Empty sequence goes straight to DONE
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd0);
    checkFlags1("len0 E0", 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkFlags1("len0 E1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkFlags1("len0 E2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Abort in IDLE, and start together with abort, both leave the player idle
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd3);
    checkFlags1("idle abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 5'd3);
    checkFlags1("start+abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd3);
    checkFlags1("start+abort next", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held for 3 clocks in the middle of a note
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd3);
    repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 5'd3);
    checkFlags1("pre-reset", 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    for (int r = 0; r < 3; r++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 5'd3);
      checkFlags1($sformatf("midreset %0d", r), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      checkOutput($sformatf("midreset %0d note_out", r), 32'(note_out1), 32'd0);
      checkOutput($sformatf("midreset %0d rd_index", r), 32'(rd_index1), 32'd0);
    end
    reset = 1'b0;
    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, 5'd3);
    checkFlags1("post-reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd1);
    checkFlags1("post-reset start", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 5'd1);
    checkFlags1("post-reset abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd1);

    // Oversized sequence is clamped to 16 notes; a second start mid-play is ignored
    for (int i = 0; i < 16; i++) mem1[i] = 3'(i % 8);
    applyStimulus(1'b0, 1'b1, 1'b0, 5'd20);
    note_cnt = 0; max_idx = 0; done_at = -1; rci_extra = 0; prev_vld = 1'b0;
    for (int k = 1; k <= 300 && done_at < 0; k++) begin
      applyStimulus(1'b0, (k == 50), 1'b0, 5'd20);
      if (rci1) rci_extra++;
      if (int'(rd_index1) > max_idx) max_idx = int'(rd_index1);
      if (vld1 && !prev_vld) begin
        checkOutput($sformatf("len20 note %0d value", note_cnt), 32'(note_out1), 32'(note_cnt % 8));
        checkOutput($sformatf("len20 note %0d rd_index", note_cnt), 32'(rd_index1), 32'(note_cnt));
        note_cnt++;
      end
      prev_vld = vld1;
      if (done1) done_at = k;
    end
    checkOutput("len20 done edge", 32'(done_at), 32'd208);
    checkOutput("len20 note count", 32'(note_cnt), 32'd16);
    checkOutput("len20 max rd_index", 32'(max_idx), 32'd15);
    checkOutput("len20 stray reset_current_index", 32'(rci_extra), 32'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 5'd0);
    checkFlags1("len20 after done", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // No-gap build: two notes separated only by a single LOAD clock
    for (int k = 0; k < 21; k++) begin
      logic ev, ep, ed;
      ev = (k >= 1 && k <= 8) || (k >= 10 && k <= 17);
      ep = (k <= 18);
      ed = (k == 18);
      applyStimulus(1'b1, (k == 0), 1'b0, 5'd2);
      checkOutput($sformatf("nogap E%0d note_valid", k), 32'(vld2), 32'(ev));
      checkOutput($sformatf("nogap E%0d is_music_playing", k), 32'(play2), 32'(ep));
      checkOutput($sformatf("nogap E%0d done", k), 32'(done2), 32'(ed));
      if (ev)
        checkOutput($sformatf("nogap E%0d note_out", k), 32'(note_out2), (k <= 8) ? 32'd3 : 32'd6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
